// File: rtl/spad_arbiter_if.sv
// Requester-side and SPad-side signals of the scratchpad arbiter.
// The arbiter takes the slave modport; the requesters and the SPad take the master modport.
interface spad_arbiter_if #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9,
  parameter int unsigned NUM_REQ       = 3
) ();

  logic [NUM_REQ-1:0]               rd_req;
  logic [NUM_REQ*ADDR_BITWIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]               rd_grant;
  logic [NUM_REQ-1:0]               rd_rsp_valid;
  logic [DATA_BITWIDTH-1:0]         rd_rsp_data;
  logic [NUM_REQ-1:0]               wr_req;
  logic [NUM_REQ*ADDR_BITWIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_BITWIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]               wr_grant;
  logic                             spad_read_req;
  logic [ADDR_BITWIDTH-1:0]         spad_r_addr;
  logic                             spad_write_en;
  logic [ADDR_BITWIDTH-1:0]         spad_w_addr;
  logic [DATA_BITWIDTH-1:0]         spad_w_data;
  logic [DATA_BITWIDTH-1:0]         spad_r_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, spad_r_data,
    input  rd_grant, rd_rsp_valid, rd_rsp_data, wr_grant,
    input  spad_read_req, spad_r_addr, spad_write_en, spad_w_addr, spad_w_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, spad_r_data,
    output rd_grant, rd_rsp_valid, rd_rsp_data, wr_grant,
    output spad_read_req, spad_r_addr, spad_write_en, spad_w_addr, spad_w_data
  );

endinterface

// File: rtl/spad_arbiter.sv
// Round-robin read/write arbiter sharing one scratchpad between NUM_REQ requesters,
// with same-cycle read-after-write deferral and one-cycle read response routing.
module spad_arbiter #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9,
  parameter int unsigned NUM_REQ       = 3
) (
  input logic            clk,
  input logic            reset,
  spad_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NUM_REQ-1:0] rsp_sel_q;

  logic               rd_found, wr_found, raw_hazard;
  logic [PtrW-1:0]    rd_idx, wr_idx;

  function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] ptr, input int unsigned k);
    return PtrW'((32'(ptr) + k) % NUM_REQ);
  endfunction

  // Winner search: first requesting index after the pointer, wrapping around.
  always_comb begin
    rd_found = 1'b0;
    rd_idx   = '0;
    wr_found = 1'b0;
    wr_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!wr_found && bus.wr_req[rr_idx(wr_ptr_q, k)]) begin
        wr_found = 1'b1;
        wr_idx   = rr_idx(wr_ptr_q, k);
      end
      if (!rd_found && bus.rd_req[rr_idx(rd_ptr_q, k)]) begin
        rd_found = 1'b1;
        rd_idx   = rr_idx(rd_ptr_q, k);
      end
    end
    // The deferred reader is not replaced by a lower-priority candidate.
    raw_hazard = rd_found && wr_found &&
                 (bus.rd_addr[rd_idx*ADDR_BITWIDTH +: ADDR_BITWIDTH] ==
                  bus.wr_addr[wr_idx*ADDR_BITWIDTH +: ADDR_BITWIDTH]);
  end

  always_comb begin
    bus.rd_grant      = '0;
    bus.wr_grant      = '0;
    bus.spad_read_req = 1'b0;
    bus.spad_r_addr   = '0;
    bus.spad_write_en = 1'b0;
    bus.spad_w_addr   = '0;
    bus.spad_w_data   = '0;
    rd_ptr_d          = rd_ptr_q;
    wr_ptr_d          = wr_ptr_q;
    if (reset) begin
      if (wr_found) begin
        bus.wr_grant[wr_idx] = 1'b1;
        bus.spad_write_en    = 1'b1;
        bus.spad_w_addr      = bus.wr_addr[wr_idx*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        bus.spad_w_data      = bus.wr_data[wr_idx*DATA_BITWIDTH +: DATA_BITWIDTH];
        wr_ptr_d             = wr_idx;
      end
      if (rd_found && !raw_hazard) begin
        bus.rd_grant[rd_idx] = 1'b1;
        bus.spad_read_req    = 1'b1;
        bus.spad_r_addr      = bus.rd_addr[rd_idx*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        rd_ptr_d             = rd_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= PtrW'(NUM_REQ - 1);
      wr_ptr_q  <= PtrW'(NUM_REQ - 1);
      rsp_sel_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rsp_sel_q <= bus.rd_grant;
    end
  end

  assign bus.rd_rsp_valid = rsp_sel_q;
  assign bus.rd_rsp_data  = bus.spad_r_data;

endmodule

// File: tb/tb_spad_arbiter.sv
// Directed bench for spad_arbiter with a registered-read SPad model.
module tb_spad_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;
  localparam int unsigned NR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spad_arbiter_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_REQ(NR)) bus ();

  spad_arbiter #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SPad model: mem[a] = 0x1000 + a initially, filler 0xF11F when not reading.
  logic [DW-1:0] mem [2**AW];
  bit            mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(32'h1000 + i);
      mem_ready       <= 1'b1;
      bus.spad_r_data <= 16'hF11F;
    end else begin
      if (bus.spad_write_en) mem[bus.spad_w_addr] <= bus.spad_w_data;
      bus.spad_r_data <= bus.spad_read_req ? mem[bus.spad_r_addr] : 16'hF11F;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input int i, input int addr);
    bus.rd_addr[i*AW +: AW] = AW'(addr);
  endtask

  task automatic set_wr(input int i, input int addr, input int data);
    bus.wr_addr[i*AW +: AW] = AW'(addr);
    bus.wr_data[i*DW +: DW] = DW'(data);
  endtask

  logic [2:0]  exp_g [6];
  logic [15:0] exp_d [6];
  logic [2:0]  exp_w [4];

  initial begin
    reset       = 1'b0;
    bus.rd_req  = 3'b111;
    bus.wr_req  = 3'b111;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset: all grants and strobes forced low
    repeat (3) next_cycle();
    settle();
    check("rst_rd_grant", bus.rd_grant, 3'b000);
    check("rst_wr_grant", bus.wr_grant, 3'b000);
    check("rst_read_req", bus.spad_read_req, 1'b0);
    check("rst_write_en", bus.spad_write_en, 1'b0);
    check("rst_rsp_valid", bus.rd_rsp_valid, 3'b000);

    // Reset then single read
    next_cycle();
    reset      = 1'b1;
    bus.wr_req = 3'b000;
    bus.rd_req = 3'b001;
    set_rd(0, 5);
    settle();
    check("single_grant", bus.rd_grant, 3'b001);
    check("single_addr", bus.spad_r_addr, 9'd5);
    check("single_rreq", bus.spad_read_req, 1'b1);
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("single_rsp_valid", bus.rd_rsp_valid, 3'b001);
    check("single_rsp_data", bus.rd_rsp_data, 16'h1005);
    check("single_idle_grant", bus.rd_grant, 3'b000);

    // Read round-robin, rd_ptr = 0 at this point
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_d = '{16'h100B, 16'h100C, 16'h100A, 16'h100B, 16'h100C, 16'h100A};
    next_cycle();
    bus.rd_req = 3'b111;
    set_rd(0, 10);
    set_rd(1, 11);
    set_rd(2, 12);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      settle();
      check("rr_grant", bus.rd_grant, exp_g[i]);
      if (i == 0) check("rr_rsp_valid0", bus.rd_rsp_valid, 3'b000);
      else begin
        check("rr_rsp_valid", bus.rd_rsp_valid, exp_g[i-1]);
        check("rr_rsp_data", bus.rd_rsp_data, exp_d[i-1]);
      end
    end
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("rr_rsp_valid_last", bus.rd_rsp_valid, 3'b001);
    check("rr_rsp_data_last", bus.rd_rsp_data, 16'h100A);

    // Write round-robin with a parallel read
    exp_w = '{3'b001, 3'b100, 3'b001, 3'b100};
    next_cycle();
    bus.wr_req = 3'b101;
    set_wr(0, 100, 16'hAAAA);
    set_wr(2, 102, 16'h5555);
    bus.rd_req = 3'b010;
    set_rd(1, 50);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      settle();
      check("wr_grant", bus.wr_grant, exp_w[i]);
      check("wr_en", bus.spad_write_en, 1'b1);
      check("wr_addr", bus.spad_w_addr, (exp_w[i] == 3'b001) ? 9'd100 : 9'd102);
      check("wr_data", bus.spad_w_data, (exp_w[i] == 3'b001) ? 16'hAAAA : 16'h5555);
      check("wr_par_rd_grant", bus.rd_grant, 3'b010);
      if (i > 0) begin
        check("wr_par_rsp_valid", bus.rd_rsp_valid, 3'b010);
        check("wr_par_rsp_data", bus.rd_rsp_data, 16'h1032);
      end
    end
    next_cycle();
    bus.wr_req = 3'b000;
    bus.rd_req = 3'b001;
    set_rd(0, 100);
    settle();
    check("rb_grant", bus.rd_grant, 3'b001);
    check("rb_no_write", bus.spad_write_en, 1'b0);
    next_cycle();
    set_rd(0, 102);
    settle();
    check("rb_valid_a", bus.rd_rsp_valid, 3'b001);
    check("rb_data_a", bus.rd_rsp_data, 16'hAAAA);
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("rb_data_b", bus.rd_rsp_data, 16'h5555);

    // RAW hazard: rd_ptr = 0, wr_ptr = 2
    next_cycle();
    bus.wr_req = 3'b001;
    set_wr(0, 24, 77);
    bus.rd_req = 3'b110;
    set_rd(1, 24);
    set_rd(2, 30);
    settle();
    check("raw_wr_grant", bus.wr_grant, 3'b001);
    check("raw_rd_grant", bus.rd_grant, 3'b000);
    check("raw_read_req", bus.spad_read_req, 1'b0);
    next_cycle();
    bus.wr_req = 3'b000;
    settle();
    check("raw_retry_grant", bus.rd_grant, 3'b010);
    next_cycle();
    bus.rd_req = 3'b100;
    settle();
    check("raw_next_grant", bus.rd_grant, 3'b100);
    check("raw_rsp_valid", bus.rd_rsp_valid, 3'b010);
    check("raw_rsp_data", bus.rd_rsp_data, 16'd77);
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("raw_rsp2_valid", bus.rd_rsp_valid, 3'b100);
    check("raw_rsp2_data", bus.rd_rsp_data, 16'h101E);

    // Reset mid-operation: rd_ptr = 2
    next_cycle();
    bus.rd_req = 3'b111;
    set_rd(0, 10);
    set_rd(1, 11);
    set_rd(2, 12);
    settle();
    check("mid_grant0", bus.rd_grant, 3'b001);
    next_cycle();
    settle();
    check("mid_grant1", bus.rd_grant, 3'b010);
    check("mid_rsp_valid", bus.rd_rsp_valid, 3'b001);
    #3;
    reset = 1'b0;
    #1;
    check("mid_async_valid", bus.rd_rsp_valid, 3'b000);
    check("mid_async_grant", bus.rd_grant, 3'b000);
    next_cycle();
    settle();
    check("mid_held_valid", bus.rd_rsp_valid, 3'b000);
    next_cycle();
    reset = 1'b1;
    settle();
    check("mid_release_grant", bus.rd_grant, 3'b001);
    check("mid_release_valid", bus.rd_rsp_valid, 3'b000);
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("mid_release_rsp", bus.rd_rsp_valid, 3'b001);

    // Idle
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      settle();
      check("idle_read_req", bus.spad_read_req, 1'b0);
      check("idle_write_en", bus.spad_write_en, 1'b0);
      check("idle_rsp_valid", bus.rd_rsp_valid, 3'b000);
    end
    next_cycle();
    bus.rd_req = 3'b100;
    set_rd(2, 7);
    settle();
    check("idle_req2_grant", bus.rd_grant, 3'b100);
    check("idle_req2_addr", bus.spad_r_addr, 9'd7);
    next_cycle();
    bus.rd_req = 3'b000;
    settle();
    check("idle_req2_valid", bus.rd_rsp_valid, 3'b100);
    check("idle_req2_data", bus.rd_rsp_data, 16'h1007);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spad_arbiter.md
# spad_arbiter

Round-robin arbiter that shares one scratchpad (SPad) between NUM_REQ requesters inside a PE. Examples of requesters are the filter, ifmap and psum sequencers. It grants at most one read and one write per cycle and drives the SPad read and write ports. It tracks the SPad's one-cycle read latency so that each read response is returned to the requester that issued it. A read-after-write hazard check defers a read that targets the address being written in the same cycle.

## Interface
- DATA_BITWIDTH, 16, SPad word width
- ADDR_BITWIDTH, 9, SPad address width
- NUM_REQ, 3, number of requesters (2..8)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_req  in  NUM_REQ  per-requester read request (level)
- rd_addr  in  NUM_REQ*ADDR_BITWIDTH  packed read addresses; requester i uses bits [i*ADDR_BITWIDTH +: ADDR_BITWIDTH]
- rd_grant  out  NUM_REQ  one-hot (or zero) read grant, combinational
- rd_rsp_valid  out  NUM_REQ  one-hot (or zero) read response valid, registered
- rd_rsp_data  out  DATA_BITWIDTH  read data, shared by all requesters, qualified by rd_rsp_valid
- wr_req  in  NUM_REQ  per-requester write request
- wr_addr  in  NUM_REQ*ADDR_BITWIDTH  packed write addresses
- wr_data  in  NUM_REQ*DATA_BITWIDTH  packed write data
- wr_grant  out  NUM_REQ  one-hot (or zero) write grant, combinational
- spad_read_req, spad_r_addr  out  1, ADDR_BITWIDTH  SPad read port
- spad_write_en, spad_w_addr, spad_w_data  out  1, ADDR_BITWIDTH, DATA_BITWIDTH  SPad write port
- spad_r_data  in  DATA_BITWIDTH  SPad registered read data

## Operation
- **Independent arbiters.** Reads and writes are arbitrated separately. Each has its own priority pointer (rd_ptr, wr_ptr), log2(NUM_REQ) bits wide.
- **Search order.** The candidate order starts at (ptr+1) mod NUM_REQ and wraps around. The first requester with its request bit set wins.
- **Pointer update.** On a grant, ptr takes the granted index. With no grant, ptr holds.
- **Write path.** A write grant to requester w drives:
  - spad_write_en=1
  - spad_w_addr = wr_addr slice w
  - spad_w_data = wr_data slice w
  - Otherwise spad_write_en=0 and addr/data are don't-care (drive 0).
- **Read path.** A read grant to requester r drives spad_read_req=1 and spad_r_addr = rd_addr slice r.
- **RAW hazard.** If the winning read candidate's address equals the address of the write granted in the same cycle:
  - no read is granted that cycle;
  - rd_ptr holds;
  - spad_read_req=0.
  - The requester retries next cycle and reads the newly written data.
  - The lower-priority read candidates are not promoted that cycle.
- **Response tracking.** Register rsp_sel <= rd_grant each cycle. Then rd_rsp_valid = rsp_sel and rd_rsp_data = spad_r_data.
  - rd_rsp_data is undefined when rd_rsp_valid=0; the SPad returns a filler value when idle.
- **Requester contract.** A requester holds its request, address and data stable until it sees the grant. It drops or changes them in the cycle after the grant.
- **Reset.** While reset=0, all combinational grants, spad_read_req and spad_write_en are forced to 0.

## Timing
- **Reset values.**
  - rd_ptr = wr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
  - rsp_sel = 0, so rd_rsp_valid = 0.
  - rd_rsp_data follows spad_r_data.
- **Asynchronous reset.** Asserting reset clears rd_rsp_valid immediately, without waiting for a clock edge. A read granted in the cycle reset asserts produces no response.
- **Grant latency.** Grants are combinational, in the same cycle as the request: zero cycles.
- **Read latency.** A read granted in cycle N has rd_rsp_valid[r]=1 and valid data in cycle N+1. With back-to-back grants, throughput is one read per cycle.
- **Write commit.** A write granted in cycle N is committed to the SPad at the edge that ends cycle N. A read of the same address granted in cycle N+1 returns the new data in cycle N+2.
- **Simultaneous read and write.** A read and a write to different addresses both proceed in the same cycle.
- **Single requester.** A sole requester holding its request is granted every cycle.
- **Fairness.** Under full load each requester is granted at least once every NUM_REQ cycles, excluding hazard-deferral cycles.

## Test plan
- **Reset then single read.** Reset release, then rd_req=3'b001, rd_addr0=5.
  - Cycle 0: rd_grant=001, spad_r_addr=5.
  - Cycle 1: rd_rsp_valid=001, rd_rsp_data = mem[5].
- **Read round-robin.** rd_req=3'b111 held for 6 cycles.
  - Grants: 001, 010, 100, 001, 010, 100.
  - rd_rsp_valid repeats the same sequence delayed by one cycle.
- **Write round-robin with parallel read.** wr_req=3'b101, write data 0xAAAA (requester 0) and 0x5555 (requester 2), and rd_req=3'b010 to another address, all held.
  - Write grants alternate 001, 100.
  - The read is granted every cycle.
  - Read-back afterwards shows both values.
- **RAW hazard.** In the same cycle, wr_req0 to addr 24 with data 77 and rd_req1 to addr 24.
  - Cycle 0: wr_grant=001, rd_grant=000.
  - Cycle 1: rd_grant=010.
  - Cycle 2: rd_rsp_valid=010, data=77.
- **Reset mid-operation.** rd_req=111 is running; assert reset mid-cycle after a grant.
  - rd_rsp_valid goes to 0 immediately.
  - After release, the first grant is 001.
- **Idle.** No requests for 10 cycles.
  - spad_read_req=0, spad_write_en=0, rd_rsp_valid=0.
  - Pointers unchanged: the next single request from requester 2 is granted immediately.
